qspi_mem_arbiter: RTL and testbench

- Shares the single Wishbone-to-QSPI memory adapter between the instruction-fetch bus (ibus, read-only) and the data bus (dbus, read/write).
- Decodes ROM/RAM from the requester address and drives the adapter's ROM/RAM select, holding it stable for the whole strobe.
- Filters illegal ROM writes and arbitrates with dbus priority plus a starvation bound for ibus.
- Sits between the CPU bus ports and the QSPI memory adapter.

---
 rtl/qspi_mem_arbiter.sv | 150 +++++++++++++++
 tb/tb_qspi_mem_arbiter.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qspi_mem_arbiter.sv
// Arbiter sharing one Wishbone-to-QSPI memory adapter between ibus (fetch) and dbus (data).
// Optional macro QSPI_MEM_ARBITER_ROMWR_ERR_EN adds dbus_err_o for discarded ROM writes.
module qspi_mem_arbiter #(
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic        clk_i,
  input  logic        rst_in,
  input  logic        ibus_stb_i,
  input  logic [22:0] ibus_adr_i,
  output logic        ibus_ack_o,
  output logic [31:0] ibus_dat_o,
  input  logic        dbus_stb_i,
  input  logic        dbus_we_i,
  input  logic [3:0]  dbus_be_i,
  input  logic [22:0] dbus_adr_i,
  input  logic [31:0] dbus_dat_i,
  output logic        dbus_ack_o,
  output logic [31:0] dbus_dat_o,
`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
  output logic        dbus_err_o,
`endif
  output logic        mem_sel_rom_ram_o,
  output logic        mem_stb_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [21:0] mem_adr_o,
  output logic [31:0] mem_dat_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_dat_i
);

  localparam logic [3:0] MaxStreak = 4'(MAX_DSTREAK);

  typedef enum logic [1:0] {StIdle, StGntI, StGntD, StDrop} state_e;

  state_e      state_q, state_d;
  logic [3:0]  streak_q, streak_d;
  logic        mem_sel_q, mem_sel_d;
  logic        mem_stb_q, mem_stb_d;
  logic        mem_we_q, mem_we_d;
  logic [3:0]  mem_be_q, mem_be_d;
  logic [21:0] mem_adr_q, mem_adr_d;
  logic [31:0] mem_dat_q, mem_dat_d;
  logic        drop_sig;

  always_comb begin
    state_d    = state_q;
    streak_d   = streak_q;
    mem_sel_d  = mem_sel_q;
    mem_stb_d  = mem_stb_q;
    mem_we_d   = mem_we_q;
    mem_be_d   = mem_be_q;
    mem_adr_d  = mem_adr_q;
    mem_dat_d  = mem_dat_q;
    ibus_ack_o = 1'b0;
    dbus_ack_o = 1'b0;
    drop_sig   = 1'b0;
    unique case (state_q)
      StIdle: begin
        mem_stb_d = 1'b0;
        if (!ibus_stb_i) streak_d = '0;
        // dbus has priority until ibus has waited out MaxStreak dbus grants
        if (dbus_stb_i && (!ibus_stb_i || (streak_q < MaxStreak))) begin
          if (dbus_we_i && !dbus_adr_i[22]) begin
            state_d = StDrop;
          end else begin
            state_d   = StGntD;
            mem_stb_d = 1'b1;
            mem_sel_d = dbus_adr_i[22];
            mem_we_d  = dbus_we_i;
            mem_be_d  = dbus_be_i;
            mem_adr_d = dbus_adr_i[21:0];
            mem_dat_d = dbus_dat_i;
            if (ibus_stb_i) streak_d = streak_q + 4'd1;
          end
        end else if (ibus_stb_i) begin
          state_d   = StGntI;
          streak_d  = '0;
          mem_stb_d = 1'b1;
          mem_sel_d = ibus_adr_i[22];
          mem_we_d  = 1'b0;
          mem_be_d  = 4'hF;
          mem_adr_d = ibus_adr_i[21:0];
        end
      end
      StGntI: begin
        ibus_ack_o = mem_ack_i;
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_stb_d = 1'b0;
        end
      end
      StGntD: begin
        dbus_ack_o = mem_ack_i;
        if (mem_ack_i) begin
          state_d   = StIdle;
          mem_stb_d = 1'b0;
        end
      end
      StDrop: begin
        drop_sig = 1'b1;
        state_d  = StIdle;
`ifndef QSPI_MEM_ARBITER_ROMWR_ERR_EN
        dbus_ack_o = 1'b1;
`endif
      end
      default: state_d = StIdle;
    endcase
  end

`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
  assign dbus_err_o = drop_sig;
`endif

  always_ff @(posedge clk_i or negedge rst_in) begin
    if (!rst_in) begin
      state_q   <= StIdle;
      streak_q  <= '0;
      mem_sel_q <= 1'b0;
      mem_stb_q <= 1'b0;
      mem_we_q  <= 1'b0;
      mem_be_q  <= '0;
      mem_adr_q <= '0;
      mem_dat_q <= '0;
    end else begin
      state_q   <= state_d;
      streak_q  <= streak_d;
      mem_sel_q <= mem_sel_d;
      mem_stb_q <= mem_stb_d;
      mem_we_q  <= mem_we_d;
      mem_be_q  <= mem_be_d;
      mem_adr_q <= mem_adr_d;
      mem_dat_q <= mem_dat_d;
    end
  end

  assign mem_sel_rom_ram_o = mem_sel_q;
  assign mem_stb_o         = mem_stb_q;
  assign mem_we_o          = mem_we_q;
  assign mem_be_o          = mem_be_q;
  assign mem_adr_o         = mem_adr_q;
  assign mem_dat_o         = mem_dat_q;
  assign ibus_dat_o        = mem_dat_i;
  assign dbus_dat_o        = mem_dat_i;

  // drop_sig is only routed to a port in the error-enabled build
  logic unused_drop;
  assign unused_drop = drop_sig;

endmodule

// File: tb/tb_qspi_mem_arbiter.sv
// Self-checking bench for qspi_mem_arbiter: vector table, directed corner sequences and a
// randomized phase checked against a transaction-level memory/fairness model.
module tb_qspi_mem_arbiter;
  localparam int unsigned MaxD = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ibus_stb, ibus_ack;
  logic [22:0] ibus_adr;
  logic [31:0] ibus_dat;
  logic        dbus_stb, dbus_we, dbus_ack;
  logic [3:0]  dbus_be;
  logic [22:0] dbus_adr;
  logic [31:0] dbus_wdat, dbus_rdat;
  logic        mem_sel, mem_stb, mem_we, mem_ack;
  logic [3:0]  mem_be;
  logic [21:0] mem_adr;
  logic [31:0] mem_wdat, mem_rdat;
  logic        d_done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  qspi_mem_arbiter #(.MAX_DSTREAK(MaxD)) dut (
    .clk_i(clk), .rst_in(rst_n),
    .ibus_stb_i(ibus_stb), .ibus_adr_i(ibus_adr), .ibus_ack_o(ibus_ack), .ibus_dat_o(ibus_dat),
    .dbus_stb_i(dbus_stb), .dbus_we_i(dbus_we), .dbus_be_i(dbus_be), .dbus_adr_i(dbus_adr),
    .dbus_dat_i(dbus_wdat), .dbus_ack_o(dbus_ack), .dbus_dat_o(dbus_rdat),
`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
    .dbus_err_o(dbus_err),
`endif
    .mem_sel_rom_ram_o(mem_sel), .mem_stb_o(mem_stb), .mem_we_o(mem_we), .mem_be_o(mem_be),
    .mem_adr_o(mem_adr), .mem_dat_o(mem_wdat), .mem_ack_i(mem_ack), .mem_dat_i(mem_rdat)
  );

`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
  logic dbus_err;
  assign d_done = dbus_ack | dbus_err;
`else
  assign d_done = dbus_ack;
`endif

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic idle_inputs();
    ibus_stb = 1'b0; ibus_adr = '0;
    dbus_stb = 1'b0; dbus_we = 1'b0; dbus_be = '0; dbus_adr = '0; dbus_wdat = '0;
    mem_ack = 1'b0; mem_rdat = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic istb; logic [22:0] iadr;
    logic dstb; logic dwe; logic [3:0] dbe; logic [22:0] dadr; logic [31:0] ddat;
    logic mack; logic [31:0] mdat;
    logic e_stb; logic e_sel; logic e_we; logic [3:0] e_be; logic [21:0] e_adr;
    logic e_iack; logic e_dack; logic e_drop;
  } vec_t;

  vec_t vecs[13];

  // Random-phase model state
  logic [31:0] marr[2][16];
  logic [31:0] rarr[2][16];

  initial begin
    bit          i_act, i_cool, d_act, d_cool, a_busy, a_ackd;
    int          a_lat, i_wait, d_wait, d_while_i, n;
    logic [22:0] ia, da;
    logic        dwe_r;
    logic [3:0]  dbe_r;
    logic [31:0] ddat_r, wv;
    logic [59:0] payload;
    byte         order[10];
    bit          prev_ack, done;

    // istb iadr dstb dwe dbe dadr ddat mack mdat | stb sel we be adr iack dack drop
    vecs[0]  = '{'0, '0, '0, '0, '0, '0, '0, '0, 32'h11111111, '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[1]  = '{1'b1, 23'h10, '0, '0, '0, '0, '0, '0, 32'h22222222,
                 '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[2]  = '{1'b1, 23'h10, '0, '0, '0, '0, '0, '0, 32'h33333333,
                 1'b1, '0, '0, 4'hF, 22'h10, '0, '0, '0};
    vecs[3]  = '{1'b1, 23'h10, '0, '0, '0, '0, '0, 1'b1, 32'hDEADBEEF,
                 1'b1, '0, '0, 4'hF, 22'h10, 1'b1, '0, '0};
    vecs[4]  = '{'0, '0, '0, '0, '0, '0, '0, '0, 32'h44444444, '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[5]  = '{'0, '0, 1'b1, 1'b1, 4'h3, 23'h400004, 32'hA5A5, '0, 32'h55555555,
                 '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[6]  = '{'0, '0, 1'b1, 1'b1, 4'h3, 23'h400004, 32'hA5A5, '0, 32'h66666666,
                 1'b1, 1'b1, 1'b1, 4'h3, 22'h4, '0, '0, '0};
    vecs[7]  = '{'0, '0, 1'b1, 1'b1, 4'h3, 23'h400004, 32'hA5A5, 1'b1, 32'h77777777,
                 1'b1, 1'b1, 1'b1, 4'h3, 22'h4, '0, 1'b1, '0};
    vecs[8]  = '{'0, '0, '0, '0, '0, '0, '0, '0, 32'h88888888, '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[9]  = '{'0, '0, 1'b1, 1'b1, 4'hF, 23'h000100, 32'h1234, '0, 32'h99999999,
                 '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[10] = '{'0, '0, 1'b1, 1'b1, 4'hF, 23'h000100, 32'h1234, '0, 32'hAAAAAAAA,
                 '0, '0, '0, '0, '0, '0, '0, 1'b1};
    vecs[11] = '{'0, '0, '0, '0, '0, '0, '0, '0, 32'hBBBBBBBB, '0, '0, '0, '0, '0, '0, '0, '0};
    vecs[12] = '{'0, '0, '0, '0, '0, '0, '0, 1'b1, 32'hCCCCCCCC,
                 '0, '0, '0, '0, '0, '0, '0, '0};

    do_reset();

    // ---------------- vector table ----------------
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      ibus_stb = vecs[i].istb; ibus_adr = vecs[i].iadr;
      dbus_stb = vecs[i].dstb; dbus_we = vecs[i].dwe; dbus_be = vecs[i].dbe;
      dbus_adr = vecs[i].dadr; dbus_wdat = vecs[i].ddat;
      mem_ack = vecs[i].mack; mem_rdat = vecs[i].mdat;
      #1;
      chk($sformatf("v%0d.mem_stb", i), mem_stb, vecs[i].e_stb);
      chk($sformatf("v%0d.ibus_ack", i), ibus_ack, vecs[i].e_iack);
`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
      chk($sformatf("v%0d.dbus_ack", i), dbus_ack, vecs[i].e_dack);
      chk($sformatf("v%0d.dbus_err", i), dbus_err, vecs[i].e_drop);
`else
      chk($sformatf("v%0d.dbus_ack", i), dbus_ack, vecs[i].e_dack | vecs[i].e_drop);
`endif
      chk($sformatf("v%0d.ibus_dat", i), ibus_dat, vecs[i].mdat);
      chk($sformatf("v%0d.dbus_dat", i), dbus_rdat, vecs[i].mdat);
      if (vecs[i].e_stb || i == 0) begin
        chk($sformatf("v%0d.mem_sel", i), mem_sel, vecs[i].e_sel);
        chk($sformatf("v%0d.mem_we", i), mem_we, vecs[i].e_we);
        chk($sformatf("v%0d.mem_be", i), mem_be, vecs[i].e_be);
        chk($sformatf("v%0d.mem_adr", i), mem_adr, vecs[i].e_adr);
        if (vecs[i].e_we || i == 0)
          chk($sformatf("v%0d.mem_dat", i), mem_wdat, vecs[i].e_we ? vecs[i].ddat : 32'h0);
      end
    end

    // ---------------- continuous contention: grant order ----------------
    do_reset();
    n = 0;
    prev_ack = 1'b0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      @(negedge clk);
      ibus_stb = 1'b1; ibus_adr = 23'h400020;
      dbus_stb = 1'b1; dbus_we = 1'b0; dbus_be = 4'hF; dbus_adr = 23'h400030;
      if (prev_ack) chk("order.stb_after_ack", mem_stb, 1'b0);
      mem_ack = mem_stb; mem_rdat = $urandom;
      #1;
      prev_ack = ibus_ack | dbus_ack;
      if (ibus_ack && dbus_ack) chk("order.dual_ack", {ibus_ack, dbus_ack}, 2'b00);
      if (dbus_ack) begin order[n] = "D"; n++; end
      else if (ibus_ack) begin order[n] = "I"; n++; end
    end
    chk("order.count", n, 10);
    for (int k = 0; k < n; k++)
      chk($sformatf("order[%0d]", k), order[k], (k % (MaxD + 1) == MaxD) ? "I" : "D");

    // ---------------- reset in the middle of a dbus grant ----------------
    do_reset();
    @(negedge clk);
    dbus_stb = 1'b1; dbus_we = 1'b0; dbus_be = 4'hF; dbus_adr = 23'h400008;
    @(negedge clk);
    chk("rst.stb_before", mem_stb, 1'b1);
    mem_ack = 1'b1;
    #1;
    chk("rst.dack_before", dbus_ack, 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst.stb_async", mem_stb, 1'b0);
    chk("rst.dack_async", dbus_ack, 1'b0);
    chk("rst.iack_async", ibus_ack, 1'b0);
    chk("rst.adr_async", {mem_sel, mem_we, mem_be, mem_adr}, '0);
    idle_inputs();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    ibus_stb = 1'b1; ibus_adr = 23'h000044;
    done = 1'b0;
    for (int c = 0; c < 10 && !done; c++) begin
      @(negedge clk);
      mem_ack = mem_stb; mem_rdat = 32'hCAFEF00D;
      #1;
      if (ibus_ack) begin
        done = 1'b1;
        chk("rst.fetch_dat", ibus_dat, 32'hCAFEF00D);
        chk("rst.fetch_adr", {mem_sel, mem_adr}, 23'h000044);
      end
    end
    chk("rst.fetch_done", done, 1'b1);

    // ---------------- randomized traffic vs. memory/fairness model ----------------
    do_reset();
    for (int s = 0; s < 2; s++)
      for (int a = 0; a < 16; a++) begin
        marr[s][a] = $urandom;
        rarr[s][a] = marr[s][a];
      end
    i_act = 0; i_cool = 0; d_act = 0; d_cool = 0; a_busy = 0; a_ackd = 0;
    a_lat = 0; i_wait = 0; d_wait = 0; d_while_i = 0;
    ia = '0; da = '0; dwe_r = 0; dbe_r = '0; ddat_r = '0; payload = '0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      @(negedge clk);
      if (i_cool) begin
        ibus_stb = 1'b0; i_cool = 0;
      end else if (!i_act && $urandom_range(0, 2) == 0) begin
        i_act = 1; ia = '0;
        ia[22] = 1'($urandom_range(0, 1)); ia[3:0] = 4'($urandom_range(0, 15));
        ibus_stb = 1'b1; ibus_adr = ia;
      end
      if (d_cool) begin
        dbus_stb = 1'b0; d_cool = 0;
      end else if (!d_act && $urandom_range(0, 1) == 0) begin
        d_act = 1; da = '0;
        da[22] = 1'($urandom_range(0, 3) != 0); da[3:0] = 4'($urandom_range(0, 15));
        dwe_r = 1'($urandom_range(0, 1)); dbe_r = 4'($urandom_range(1, 15)); ddat_r = $urandom;
        dbus_stb = 1'b1; dbus_we = dwe_r; dbus_be = dbe_r; dbus_adr = da; dbus_wdat = ddat_r;
      end
      // adapter model
      if (a_ackd) begin
        chk("rnd.stb_after_ack", mem_stb, 1'b0);
        a_ackd = 0;
      end
      mem_ack = 1'b0; mem_rdat = $urandom;
      if (mem_stb) begin
        if (!a_busy) begin
          a_busy = 1;
          payload = {mem_sel, mem_we, mem_be, mem_adr, mem_wdat};
          a_lat = $urandom_range(0, 3);
          chk("rnd.no_rom_write", mem_we & ~mem_sel, 1'b0);
        end else begin
          chk("rnd.payload_stable", {mem_sel, mem_we, mem_be, mem_adr, mem_wdat}, payload);
        end
        if (a_lat == 0) begin
          mem_ack = 1'b1;
          if (mem_we) begin
            wv = marr[mem_sel][mem_adr[3:0]];
            for (int b = 0; b < 4; b++) if (mem_be[b]) wv[8*b +: 8] = mem_wdat[8*b +: 8];
            marr[mem_sel][mem_adr[3:0]] = wv;
          end else begin
            mem_rdat = marr[mem_sel][mem_adr[3:0]];
          end
          a_busy = 0; a_ackd = 1;
        end else begin
          a_lat--;
        end
      end
      #1;
      if (ibus_ack) begin
        chk("rnd.i_req_active", i_act, 1'b1);
        chk("rnd.i_with_mem_ack", mem_ack, 1'b1);
        chk("rnd.i_rdata", ibus_dat, rarr[ia[22]][ia[3:0]]);
        i_act = 0; i_cool = 1; i_wait = 0; d_while_i = 0;
      end
      if (d_done) begin
        chk("rnd.d_req_active", d_act, 1'b1);
        chk("rnd.no_dual_ack", ibus_ack, 1'b0);
        if (!(dwe_r && !da[22])) begin
          chk("rnd.d_with_mem_ack", mem_ack, 1'b1);
`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
          chk("rnd.d_no_err", dbus_err, 1'b0);
`endif
          if (dwe_r) begin
            wv = rarr[1][da[3:0]];
            for (int b = 0; b < 4; b++) if (dbe_r[b]) wv[8*b +: 8] = ddat_r[8*b +: 8];
            rarr[1][da[3:0]] = wv;
          end else begin
            chk("rnd.d_rdata", dbus_rdat, rarr[da[22]][da[3:0]]);
          end
          if (i_act) begin
            d_while_i++;
            chk("rnd.ibus_starve", d_while_i <= int'(MaxD) + 1, 1'b1);
          end
        end else begin
`ifdef QSPI_MEM_ARBITER_ROMWR_ERR_EN
          chk("rnd.rom_wr_err", {dbus_err, dbus_ack}, 2'b10);
`else
          chk("rnd.rom_wr_ack", dbus_ack, 1'b1);
`endif
        end
        d_act = 0; d_cool = 1; d_wait = 0;
      end
      if (i_act) i_wait++;
      if (d_act) d_wait++;
      if (i_wait > 200 || d_wait > 200) begin
        chk("rnd.timeout", {i_wait > 200, d_wait > 200}, 2'b00);
        break;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule
